stream_fifo: RTL

Parametrised synchronous stream FIFO carrying data, byte-keep and last, with valid/ready handshakes on both sides, first-word-fall-through output, occupancy and threshold flags, and an optional packet (store-and-forward) mode. It sits between the UDP packet-processing stages wherever a stage needs elasticity or whole-packet buffering, and is the general-depth replacement for the fixed 4-entry stream FIFO.

---
 rtl/stream_pkg.sv | 9 +
 rtl/fifo_mem.sv | 23 ++
 rtl/stream_fifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared helpers for the stream datapath blocks. The word struct itself is
// declared in each user module, since its width follows that module's WIDTH.
package stream_pkg;

   function automatic int keep_width(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// There is no reset, so the array maps onto LUTRAM.
module fifo_mem #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// Stream FIFO with first-word-fall-through output. The head word always lives in
// hd_q, and the memory holds the words queued behind it. An optional packet mode gates the output until a full packet is held.
module stream_fifo
   import stream_pkg::*;
#(
   parameter int WIDTH      = 256,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 2,
   parameter int AE_THRESH  = 1,
   parameter bit PKT_MODE   = 1'b0,
   localparam int KEEP_W    = keep_width(WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [WIDTH-1:0]    s_data,
   input  logic [KEEP_W-1:0]   s_keep,
   input  logic                s_last,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WIDTH-1:0]    m_data,
   output logic [KEEP_W-1:0]   m_keep,
   output logic                m_last,
   output logic [DEPTH_LOG2:0] level,
   output logic [DEPTH_LOG2:0] pkt_count,
   output logic                almost_full,
   output logic                almost_empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 1;
   localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
   localparam logic [LW-1:0] ONE_L  = LW'(1);
   localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

   typedef struct packed {
      logic [WIDTH-1:0]  data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } stream_word_t;

   stream_word_t s_word, mem_rd, hd_q, hd_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d, pkt_q, pkt_d;
   logic push, pop, byp, reload, mem_we;

   assign s_word = '{data: s_data, keep: s_keep, last: s_last};

   // In packet mode, a completely full FIFO also releases the head word.
   // Otherwise a packet longer than DEPTH would deadlock.
   assign s_ready = (level_q != FULL_L);
   assign m_valid = (level_q != '0) && (!PKT_MODE || pkt_q != '0 || level_q == FULL_L);

   assign push   = s_valid && s_ready;
   assign pop    = m_valid && m_ready;
   assign byp    = push && (level_q == '0 || (level_q == ONE_L && pop));
   assign reload = pop && (level_q > ONE_L);
   assign mem_we = push && !byp;

   always_comb begin
      hd_d     = hd_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      pkt_d    = pkt_q;
      if (byp)         hd_d = s_word;
      else if (reload) hd_d = mem_rd;
      if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
      if (reload) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + ONE_L;
         2'b01:   level_d = level_q - ONE_L;
         default: level_d = level_q;
      endcase
      case ({push && s_last, pop && hd_q.last})
         2'b10:   pkt_d = pkt_q + ONE_L;
         2'b01:   pkt_d = pkt_q - ONE_L;
         default: pkt_d = pkt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         pkt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         pkt_q    <= pkt_d;
      end
   end

   // The head contents only matter while level > 0, so they need no reset.
   always_ff @(posedge clk) begin
      hd_q <= hd_d;
   end

   fifo_mem #(
      .AW (DEPTH_LOG2),
      .DW ($bits(stream_word_t))
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (s_word),
      .raddr_i (rd_ptr_q),
      .rdata_o (mem_rd)
   );

   assign m_data       = hd_q.data;
   assign m_keep       = hd_q.keep;
   assign m_last       = hd_q.last;
   assign level        = level_q;
   assign pkt_count    = pkt_q;
   assign almost_full  = (level_q >= AF_L);
   assign almost_empty = (level_q <= AE_L);

endmodule
